// File: rtl/cpu_types_pkg.sv
// Shared types for the five-stage core: register index, hazard FSM state
// and the bundle of pipeline sequencing controls.
// Optional feature macro used by hazard_unit: HAZARD_PERF_EN.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hz_state_t;

    // One enable/flush pair per pipeline latch, plus the PC load enable.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } hz_ctrl_t;

    // Canned control patterns, one per sequencing decision. Any latch that
    // is flushed also has its enable low, so "flush wins" holds by design.
    localparam hz_ctrl_t CTRL_RESET  = '{pc_en:1'b0, ifid_en:1'b0, idex_en:1'b0, exmem_en:1'b0, memwb_en:1'b0,
                                         ifid_flush:1'b1, idex_flush:1'b1, exmem_flush:1'b1, memwb_flush:1'b1};
    localparam hz_ctrl_t CTRL_FREEZE = '{pc_en:1'b0, ifid_en:1'b0, idex_en:1'b0, exmem_en:1'b0, memwb_en:1'b0,
                                         ifid_flush:1'b0, idex_flush:1'b0, exmem_flush:1'b0, memwb_flush:1'b0};
    localparam hz_ctrl_t CTRL_DWAIT  = '{pc_en:1'b0, ifid_en:1'b0, idex_en:1'b0, exmem_en:1'b0, memwb_en:1'b0,
                                         ifid_flush:1'b0, idex_flush:1'b0, exmem_flush:1'b0, memwb_flush:1'b1};
    localparam hz_ctrl_t CTRL_BRANCH = '{pc_en:1'b1, ifid_en:1'b0, idex_en:1'b0, exmem_en:1'b1, memwb_en:1'b1,
                                         ifid_flush:1'b1, idex_flush:1'b1, exmem_flush:1'b0, memwb_flush:1'b0};
    localparam hz_ctrl_t CTRL_JUMP   = '{pc_en:1'b1, ifid_en:1'b0, idex_en:1'b1, exmem_en:1'b1, memwb_en:1'b1,
                                         ifid_flush:1'b1, idex_flush:1'b0, exmem_flush:1'b0, memwb_flush:1'b0};
    localparam hz_ctrl_t CTRL_LDUSE  = '{pc_en:1'b0, ifid_en:1'b0, idex_en:1'b0, exmem_en:1'b1, memwb_en:1'b1,
                                         ifid_flush:1'b0, idex_flush:1'b1, exmem_flush:1'b0, memwb_flush:1'b0};
    localparam hz_ctrl_t CTRL_IMISS  = '{pc_en:1'b0, ifid_en:1'b0, idex_en:1'b1, exmem_en:1'b1, memwb_en:1'b1,
                                         ifid_flush:1'b1, idex_flush:1'b0, exmem_flush:1'b0, memwb_flush:1'b0};
    localparam hz_ctrl_t CTRL_ADVANCE = '{pc_en:1'b1, ifid_en:1'b1, idex_en:1'b1, exmem_en:1'b1, memwb_en:1'b1,
                                          ifid_flush:1'b0, idex_flush:1'b0, exmem_flush:1'b0, memwb_flush:1'b0};

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall and flush cycle counters for the hazard unit. Both wrap modulo
// 2^CNT_W and clear on the synchronous reset. Built only with HAZARD_PERF_EN.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_cycles
);

    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_cycles;

    // Count qualifying cycles; natural binary overflow gives the wrap.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (i_stall) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (i_flush) r_flush_cycles <= r_flush_cycles + CNT_W'(1);
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_cycles = r_flush_cycles;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline sequencing controller: per-cycle advance/hold/bubble decision for
// the PC and the IFID, IDEX, EXMEM and MEMWB latches.
// Optional macro HAZARD_PERF_EN builds the stall/flush performance counters;
// without it stall_cycles and flush_cycles are tied to zero.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_halt,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             idex_memread,
    input  regbits_t         idex_rd,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    hz_state_t r_state;
    hz_state_t w_next_state;
    hz_ctrl_t  w_ctrl;
    logic      w_mem_pending;
    logic      w_data_wait;
    logic      w_halt_freeze;
    logic      w_load_use;
    logic      w_redirect;

    // A dmem access that completes in the cycle it reaches MEM never stalls.
    assign w_mem_pending = exmem_dREN | exmem_dWEN;
    assign w_data_wait   = ((r_state == DWAIT) | ((r_state == RUN) & w_mem_pending)) & ~dhit;
    assign w_halt_freeze = (r_state == HALT) | ((r_state == RUN) & exmem_halt);
    // $0 is hardwired zero, so a load targeting it creates no dependency.
    assign w_load_use    = idex_memread & (idex_rd != '0)
                         & ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));

    // State register; RST wins over any pending transition, including HALT.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= RUN;
        else     r_state <= w_next_state;
    end

    // Next-state: misses park in DWAIT until dhit, an accepted halt is absorbing.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            RUN: begin
                if (w_mem_pending & ~dhit) w_next_state = DWAIT;
                else if (exmem_halt)       w_next_state = HALT;
            end
            DWAIT: if (dhit) w_next_state = RUN;
            HALT:  w_next_state = HALT;
            default: w_next_state = RUN;
        endcase
    end

    // Priority-ordered control decision; later branches never override earlier ones.
    always_comb begin
        w_ctrl     = CTRL_ADVANCE;
        w_redirect = 1'b0;
        if (RST) begin
            w_ctrl = CTRL_RESET;
        end else if (w_halt_freeze) begin
            w_ctrl = CTRL_FREEZE;
        end else if (w_data_wait) begin
            // dmem owns the shared memory port, so ihit is meaningless here.
            w_ctrl = CTRL_DWAIT;
        end else if (ex_branch_taken) begin
            w_ctrl     = CTRL_BRANCH;
            w_redirect = 1'b1;
        end else if (id_jump) begin
            w_ctrl     = CTRL_JUMP;
            w_redirect = 1'b1;
        end else if (w_load_use) begin
            w_ctrl = CTRL_LDUSE;
        end else if (~ihit) begin
            w_ctrl = CTRL_IMISS;
        end
    end

    assign pc_en       = w_ctrl.pc_en;
    assign ifid_en     = w_ctrl.ifid_en;
    assign idex_en     = w_ctrl.idex_en;
    assign exmem_en    = w_ctrl.exmem_en;
    assign memwb_en    = w_ctrl.memwb_en;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_flush  = w_ctrl.idex_flush;
    assign exmem_flush = w_ctrl.exmem_flush;
    assign memwb_flush = w_ctrl.memwb_flush;
    assign halted      = (r_state == HALT);

`ifdef HAZARD_PERF_EN
    logic w_stall_evt;

    assign w_stall_evt = ~w_ctrl.pc_en & (r_state != HALT);

    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .CLK            (CLK),
        .RST            (RST),
        .i_stall        (w_stall_evt),
        .i_flush        (w_redirect),
        .o_stall_cycles (stall_cycles),
        .o_flush_cycles (flush_cycles)
    );
`else
    logic w_unused;

    assign w_unused     = w_redirect;
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule
